// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared states, constants and CRC step for the USB transmit scheduler
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      PID,
      PAYLOAD,
      CRC_LO,
      CRC_HI,
      EOP,
      GAP
   } tx_sched_state_t;

   localparam logic [7:0]  SYNC_BYTE    = 8'h80;

   localparam logic [3:0]  PID_ACK      = 4'b0010;
   localparam logic [3:0]  PID_NAK      = 4'b1010;
   localparam logic [3:0]  PID_STALL    = 4'b1110;
   localparam logic [3:0]  PID_DATA0    = 4'b0011;
   localparam logic [3:0]  PID_DATA1    = 4'b1011;

   localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY_R = 16'hA001;

   // PID goes on the wire with its check nibble (the complement) in the upper half
   function automatic logic [7:0] pid_byte(input logic [3:0] pid);
      return {~pid, pid};
   endfunction

   // One byte of reflected CRC16, bits consumed LSB first
   function automatic logic [15:0] crc16_byte_next(input logic [15:0] crc,
                                                   input logic [7:0]  data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// rtl/usb_crc16_byte.sv - byte-serial USB CRC16 register with clear and enable
module usb_crc16_byte
   import usb_tx_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] crc
);

   // Clear wins over update so a new packet always starts from the seed
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         crc <= CRC16_INIT;
      end else if (clr) begin
         crc <= CRC16_INIT;
      end else if (en) begin
         crc <= crc16_byte_next(crc, data);
      end
   end

endmodule

// File: rtl/usb_tx_sched.sv
// rtl/usb_tx_sched.sv - per-packet arbiter and byte sequencer in front of the USB serializer
module usb_tx_sched
   import usb_tx_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int IPG_CYCLES   = 16,
   parameter int MAX_LEN      = 64
)(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       hs_req,
   input  logic [3:0] hs_pid,
   output logic       hs_done,
   input  logic       dp_req,
   input  logic [3:0] dp_pid,
   input  logic [6:0] dp_len,
   input  logic [7:0] dp_byte,
   output logic       dp_pop,
   output logic       dp_done,
   input  logic       tx_ready,
   output logic [7:0] tx_byte,
   output logic       tx_load,
   output logic       tx_eop,
   input  logic       tx_eop_done,
   output logic       busy
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [GW-1:0] GAP_LAST   = GW'(IPG_CYCLES - 1);
   localparam logic [6:0]    LEN_MAX    = 7'(MAX_LEN);

   tx_sched_state_t state;
   logic            owner_dp;
   logic [3:0]      pid_q;
   logic [6:0]      remain;
   logic [SW-1:0]   starve_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [15:0]     crc;

   logic            byte_state;
   logic            hs_win;
   logic            grant;
   logic [6:0]      len_clamped;

   // Arbitration terms, only acted on while IDLE
   always_comb begin
      byte_state  = (state == SYNC) || (state == PID) || (state == PAYLOAD) ||
                    (state == CRC_LO) || (state == CRC_HI);
      hs_win      = hs_req && (!dp_req || (starve_cnt < STARVE_MAX));
      grant       = (state == IDLE) && (hs_req || dp_req);
      len_clamped = (dp_len > LEN_MAX) ? LEN_MAX : dp_len;
   end

   // Byte presented to the serializer; zero whenever no byte is being offered
   always_comb begin
      tx_byte = 8'h00;
      case (state)
         SYNC:    tx_byte = SYNC_BYTE;
         PID:     tx_byte = pid_byte(pid_q);
         PAYLOAD: tx_byte = dp_byte;
         CRC_LO:  tx_byte = ~crc[7:0];
         CRC_HI:  tx_byte = ~crc[15:8];
         default: tx_byte = 8'h00;
      endcase
   end

   assign tx_load = byte_state && tx_ready;
   assign dp_pop  = (state == PAYLOAD) && tx_ready;
   assign tx_eop  = (state == EOP);
   assign hs_done = (state == EOP) && tx_eop_done && !owner_dp;
   assign dp_done = (state == EOP) && tx_eop_done && owner_dp;
   assign busy    = (state != IDLE);

   usb_crc16_byte u_crc (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (grant),
      .en    (dp_pop),
      .data  (dp_byte),
      .crc   (crc)
   );

   // Packet sequencer: grant and latch in IDLE, then walk bytes on tx_ready
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= IDLE;
         owner_dp   <= 1'b0;
         pid_q      <= 4'h0;
         remain     <= 7'd0;
         starve_cnt <= '0;
         gap_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state <= SYNC;
                  if (hs_win) begin
                     owner_dp <= 1'b0;
                     pid_q    <= hs_pid;
                     remain   <= 7'd0;
                     if (dp_req && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                     end
                  end else begin
                     owner_dp   <= 1'b1;
                     pid_q      <= dp_pid;
                     remain     <= len_clamped;
                     starve_cnt <= '0;
                  end
               end
            end
            SYNC: begin
               if (tx_ready) state <= PID;
            end
            PID: begin
               if (tx_ready) begin
                  if (!owner_dp)            state <= EOP;
                  else if (remain != 7'd0)  state <= PAYLOAD;
                  else                      state <= CRC_LO;
               end
            end
            PAYLOAD: begin
               if (tx_ready) begin
                  remain <= remain - 1'b1;
                  if (remain == 7'd1) state <= CRC_LO;
               end
            end
            CRC_LO: begin
               if (tx_ready) state <= CRC_HI;
            end
            CRC_HI: begin
               if (tx_ready) state <= EOP;
            end
            EOP: begin
               if (tx_eop_done) begin
                  state   <= GAP;
                  gap_cnt <= '0;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) state <= IDLE;
               else                     gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/usb_tx_sched.md
Name: usb_tx_sched

Overview:
Transmit-side scheduler that shares the USB byte serializer between two requesters: the handshake responder and the encrypted-data packet source. It arbitrates per packet and drives SYNC, PID, payload, CRC16 and EOP into the serializer, pacing each byte on the serializer's ready. The data source is drained through a pop strobe, and CRC16 is generated on the fly. It sits between the packet FIFOs and the NRZI/bit-stuff serializer.

Parameters:
STARVE_LIMIT, 4, number of consecutive handshake grants allowed while dp_req is pending before data wins.
IPG_CYCLES, 16, idle clocks enforced after EOP completes before the next arbitration.
MAX_LEN, 64, maximum payload bytes; dp_len values above this are clamped.

Ports:
clk  in  1  system clock
n_rst  in  1  reset, synchronous, active-low
hs_req  in  1  handshake packet pending (level)
hs_pid  in  4  handshake PID, valid while hs_req
hs_done  out  1  one-cycle pulse when the handshake EOP completes
dp_req  in  1  data packet pending (level)
dp_pid  in  4  data PID, valid while dp_req
dp_len  in  7  payload byte count, 0..MAX_LEN, sampled at grant
dp_byte  in  8  head payload byte from the data FIFO
dp_pop  out  1  one-cycle pulse, FIFO head consumed
dp_done  out  1  one-cycle pulse when the data-packet EOP completes
tx_ready  in  1  serializer can accept a byte this cycle
tx_byte  out  8  byte to serializer
tx_load  out  1  one-cycle strobe, tx_byte accepted (only when tx_ready=1)
tx_eop  out  1  level, request EOP; held until tx_eop_done
tx_eop_done  in  1  serializer finished EOP
busy  out  1  high in every state except IDLE

Behaviour:
- Clock is clk. Reset is n_rst, synchronous and active-low, sampled only on the clk rising edge.
- Reset values: all outputs 0; tx_byte=8'h00; state=IDLE; starvation counter=0; CRC register=16'hFFFF.
- A reset during an active packet aborts it on the next edge, with no done pulse and no dp_pop.
- States: IDLE, SYNC, PID, PAYLOAD, CRC_LO, CRC_HI, EOP, GAP.
- IDLE: if neither request is set, stay in IDLE. Otherwise grant and latch the owner, pid and len (clamped to MAX_LEN), clear the CRC register to 16'hFFFF, and go to SYNC.
- Arbitration:
  - hs wins if hs_req=1 and (dp_req=0 or starve_cnt<STARVE_LIMIT).
  - Otherwise dp wins.
  - starve_cnt increments on an hs grant while dp_req=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on any dp grant.
  - There is no preemption mid-packet.
- Byte states (SYNC, PID, PAYLOAD, CRC_LO, CRC_HI): drive tx_byte combinationally. On a cycle with tx_ready=1, assert tx_load for exactly one cycle and advance. While tx_ready=0, hold the state.
- Byte values:
  - SYNC_BYTE=8'h80.
  - PID byte={~pid,pid}.
  - Payload=dp_byte. dp_pop is asserted in the same cycle as tx_load. The CRC updates with dp_byte in that cycle. A remaining-count decrements.
  - CRC_LO=~crc[7:0], CRC_HI=~crc[15:8].
- Sequencing:
  - After PID: an hs packet goes to EOP.
  - A dp packet goes to PAYLOAD if len>0, else to CRC_LO.
  - PAYLOAD exits to CRC_LO after the len-th byte loads.
- EOP: tx_eop=1 until the cycle tx_eop_done=1. In that cycle, pulse hs_done or dp_done and go to GAP.
- GAP: count IPG_CYCLES clocks, then go to IDLE. busy stays 1 throughout GAP.
- CRC: USB CRC16, polynomial 16'h8005 in reflected form (16'hA001). Processing is LSB-first and byte-serial with a 1-cycle update. It is transmitted complemented. A zero-length payload yields bytes 8'h00, 8'h00.
- Requester changes (request drop, pid or len change) after grant are ignored until IDLE.
- tx_eop_done outside the EOP state is ignored.

Decomposition:
- Package usb_tx_pkg holds:
  - the state enum tx_sched_state_t;
  - SYNC_BYTE;
  - the PID constants PID_ACK=4'b0010, PID_NAK=4'b1010, PID_STALL=4'b1110, PID_DATA0=4'b0011, PID_DATA1=4'b1011;
  - CRC16_INIT=16'hFFFF and CRC16_POLY_R=16'hA001.
- One sub-module, usb_crc16_byte: clear/enable/byte in, registered 16-bit CRC out.

Test Plan:
1. hs_req=1, hs_pid=ACK, tx_ready=1 constant -> tx_load bytes 80, D2; tx_eop high; on tx_eop_done, hs_done pulses; busy falls after 16 GAP cycles.
2. dp_req=1, DATA0, dp_len=0 -> bytes 80, C3, 00, 00, then EOP; no dp_pop; dp_done pulses once.
3. dp_req DATA1, len=4, bytes 01 02 03 04, tx_ready toggling 1-of-8 cycles -> bytes 80, 4B, 01..04, then CRC_LO/CRC_HI matching the reference-model CRC16; exactly four dp_pop pulses, each aligned to tx_load.
4. hs_req and dp_req held high continuously -> grant order hs,hs,hs,hs,dp,hs,...; starve_cnt clears after the dp grant.
5. Reset asserted in PAYLOAD after byte 2 -> next cycle all outputs 0, state IDLE, no done pulse; a later packet's CRC is correct (CRC reinitialised).
6. hs_req rises mid-dp-packet -> dp completes uninterrupted, then hs is granted after GAP; dp_len=100 -> clamped to 64 pops.
